key_schedule_ctrl: RTL and testbench
====================================

# key_schedule_ctrl

Sequential controller for AES-128 key expansion. It accepts a cipher key through a start handshake and drives one combinational `KeyGeneration` round-step instance iteratively, once per clock. It streams round keys 0..10 to the encryption datapath. Optionally it retains all eleven round keys in a local bank, so decryption can read them in reverse order without re-expanding.

## Interface
Parameters:
- none (AES-128 only; round count fixed at 10)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request expansion of `key_in`; sampled only when `busy`=0
- key_in  in  128  cipher key, word 0 in [127:96]; sampled in the start-accept cycle only
- busy  out  1  expansion in progress
- rk_valid  out  1  `rk_out`/`rk_round` carry a valid round key this cycle
- rk_round  out  4  round index 0..10 of `rk_out`
- rk_out  out  128  current round key (registered)
- done  out  1  one-cycle pulse coincident with round-10 key
- keys_valid  out  1  bank holds a complete schedule (KEY_STORE_EN only, else 0)
- rd_addr  in  4  bank read address 0..10
- rd_key  out  128  bank read data (KEY_STORE_EN only, else 0)

## Operation
- FSM states: IDLE, EXPAND.
- IDLE:
  - `start`=1 -> load `cur_key`<=`key_in`, `rnd`<=0, go to EXPAND.
  - `start`=0 -> stay in IDLE.
- EXPAND, every cycle:
  - outputs `rk_valid`=1, `rk_round`=`rnd`, `rk_out`=`cur_key`.
  - if `rnd`<10: `cur_key`<=keyout of the step instance (rc=`rnd`, key=`cur_key`), `rnd`<=`rnd`+1.
  - if `rnd`=10: `done`=1, return to IDLE.
- The step instance's rc input is `rnd` (0..9), giving Rcon 01,02,04,08,10,20,40,80,1b,36. `rnd`=10 never reaches the Rcon lookup.
- `busy`=1 in EXPAND, else 0.
- `start` while `busy`=1 is ignored: no queuing, no error.
- `key_in` changes after acceptance have no effect.
- `rst` in any state, including mid-expansion:
  - aborts expansion and returns to IDLE next edge.
  - clears `keys_valid`; bank contents are don't-care.
- Reset values: `busy`=0, `rk_valid`=0, `rk_round`=0, `rk_out`=0, `done`=0, `keys_valid`=0, `rd_key`=0; FSM=IDLE, `rnd`=0.

## Timing
- Start sampled at edge T (`start`=1, `busy`=0).
- Edges T+1..T+11: `rk_valid`=1 with `rk_round`=0..10 in consecutive cycles; no gaps, no backpressure.
- Round-10 cycle (after edge T+11): `done`=1.
- After edge T+12: `busy`=0.
- Earliest next accepted `start` is sampled at edge T+12, i.e. 12-cycle issue interval.
- `start`=1 held continuously gives back-to-back expansions every 12 cycles.
- Latency from start to round-k key: k+1 cycles.
- Step logic is one 128-bit combinational hop (4 S-box lookups + XOR chain) between `cur_key` and its next-state input. The critical path stays inside this block.

## Configuration
- Macro `KEY_STORE_EN`.
- Defined:
  - 11x128 register bank; entry `rk_round` written whenever `rk_valid`=1.
  - `rd_key` registered: data for `rd_addr` appears one cycle later.
  - `rd_addr`>10 returns 0.
  - Reads during EXPAND return current contents, possibly mixed old/new schedules.
  - `keys_valid` set on the cycle after `done`, cleared on start acceptance or `rst`.
- Undefined:
  - no bank.
  - `rd_key` and `keys_valid` tied to 0; `rd_addr` unused.
  - streaming behaviour identical.

## Test plan
- Key `2b7e151628aed2a6abf7158809cf4f3c`, start at T -> the following, with `done`=1 only at round 10 and `busy` falling after T+12:
  - round 0 = same value at T+1.
  - round 1 = `a0fafe1788542cb123a339392a6c7605` at T+2.
  - round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6` at T+11.
- Key all-zero -> round 1 = `62636363626363636263636362636363`, round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `start` re-pulsed at T+5 with a different `key_in` -> ignored; stream continues unchanged to round 10.
- `rst` asserted at T+6 -> next cycle all outputs 0, `busy`=0. A new start at T+8 gives a clean full stream with round 0 at T+9.
- `start` held high continuously -> `rk_round` sequence 0..10 repeats every 12 cycles, with one `rk_valid`=0 cycle between streams.
- KEY_STORE_EN: after the first scenario, `rd_addr`=1 -> `rd_key`=`a0fafe17...2a6c7605` one cycle later; `rd_addr`=10 -> `d014f9a8...b6630ca6`; `rd_addr`=12 -> 0; `keys_valid`=1. Without the macro, `rd_key`=0 throughout.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
// Start/round-key stream and key-bank read bundle for key_schedule_ctrl.
interface key_schedule_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_addr,
    input  busy, rk_valid, rk_round, rk_out, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr,
    output busy, rk_valid, rk_round, rk_out, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one KeyGeneration round step per clock, round keys 0..10 streamed.
// Optional round-key bank for reverse-order reads is enabled by defining KEY_STORE_EN.
module key_schedule_ctrl (
  input  logic               clk,
  input  logic               rst,
  key_schedule_ctrl_if.slave bus
);
  typedef enum logic {IDLE, EXPAND} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // KeyGeneration round step: RotWord/SubWord/Rcon on word 3, then the four-word XOR chain.
  function automatic logic [127:0] KeyGeneration(input logic [3:0] rc, input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, t, w4, w5, w6, w7;
    {w0, w1, w2, w3} = key;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(rc), 24'h0};
    w4 = w0 ^ t;
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  state_e       state_q;
  logic [127:0] cur_key_q;
  logic [3:0]   rnd_q;
  logic         busy_q;
  logic         rk_valid_q;
  logic [3:0]   rk_round_q;
  logic [127:0] rk_out_q;
  logic         done_q;
  logic [127:0] keyout;

  always_comb begin
    keyout = KeyGeneration(rnd_q, cur_key_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_key_q  <= '0;
      rnd_q      <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_round_q <= '0;
      rk_out_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rk_valid_q <= 1'b0;
          done_q     <= 1'b0;
          if (bus.start) begin
            state_q   <= EXPAND;
            busy_q    <= 1'b1;
            cur_key_q <= bus.key_in;
            rnd_q     <= '0;
          end
        end
        EXPAND: begin
          rk_valid_q <= 1'b1;
          rk_round_q <= rnd_q;
          rk_out_q   <= cur_key_q;
          // busy drops with the round-10 output so a new start can be taken on the next edge
          if (rnd_q == 4'd10) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q    <= 1'b0;
            cur_key_q <= keyout;
            rnd_q     <= rnd_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_round = rk_round_q;
  assign bus.rk_out   = rk_out_q;
  assign bus.done     = done_q;

`ifdef KEY_STORE_EN
  logic [127:0] bank_q [0:10];
  logic [127:0] rd_key_q;
  logic         keys_valid_q;

  always_ff @(posedge clk) begin
    if (rk_valid_q) begin
      bank_q[rk_round_q] <= rk_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q     <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      rd_key_q <= (bus.rd_addr <= 4'd10) ? bank_q[bus.rd_addr] : '0;
      // a newly accepted start invalidates the bank even if the previous done is still pending
      if (state_q == IDLE && bus.start) begin
        keys_valid_q <= 1'b0;
      end else if (done_q) begin
        keys_valid_q <= 1'b1;
      end
    end
  end

  assign bus.rd_key     = rd_key_q;
  assign bus.keys_valid = keys_valid_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rd_addr;
  assign bus.rd_key     = '0;
  assign bus.keys_valid = 1'b0;
`endif
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: random keys against a GF(2^8)-arithmetic key expansion model.
module tb_key_schedule_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_ctrl_if bus();
  key_schedule_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] exp_a [11];

  logic         obs_valid [32];
  logic [3:0]   obs_round [32];
  logic [127:0] obs_out   [32];
  logic         obs_done  [32];
  logic         obs_busy  [32];
  logic         obs_kv    [32];
  logic [127:0] obs_rdk   [32];
  logic [127:0] obs_kin   [32];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a start for key at edge T, then records outputs after edges T+1..T+n.
  task automatic capture(input logic [127:0] key, input bit hold, input int restart_e,
                         input int rst_e, input int n);
    bus.start = 1'b1;
    bus.key_in = key;
    tick();
    for (int e = 1; e <= n; e++) begin
      bus.start   = hold || (e == restart_e);
      bus.key_in  = rand128();
      obs_kin[e]  = bus.key_in;
      rst         = (e == rst_e);
      bus.rd_addr = 4'($urandom_range(0, 15));
      tick();
      obs_valid[e] = bus.rk_valid;
      obs_round[e] = bus.rk_round;
      obs_out[e]   = bus.rk_out;
      obs_done[e]  = bus.done;
      obs_busy[e]  = bus.busy;
      obs_kv[e]    = bus.keys_valid;
      obs_rdk[e]   = bus.rd_key;
    end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.key_in = rand128();
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b expected 0", bus.rk_valid); end
    checks++; if (bus.rk_round !== 4'd0) begin errors++; $display("FAIL reset_rk_round: got %0d expected 0", bus.rk_round); end
    checks++; if (bus.rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h expected 0", bus.rk_out); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %b expected 0", bus.keys_valid); end
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL reset_rd_key: got %h expected 0", bus.rd_key); end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_key;
    logic [127:0] key;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(key);
    capture(key, 1'b0, -1, -1, 12);
    checks++; if (obs_out[1] !== key) begin errors++; $display("FAIL known_round0: got %h expected %h", obs_out[1], key); end
    checks++; if (obs_out[2] !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL known_round1: got %h expected a0fafe1788542cb123a339392a6c7605", obs_out[2]); end
    checks++; if (obs_out[11] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL known_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", obs_out[11]); end
    for (int e = 1; e <= 11; e++) begin
      checks++; if (obs_valid[e] !== 1'b1) begin errors++; $display("FAIL known_valid[%0d]: got %b expected 1", e, obs_valid[e]); end
      checks++; if (obs_round[e] !== 4'(e - 1)) begin errors++; $display("FAIL known_round[%0d]: got %0d expected %0d", e, obs_round[e], e - 1); end
      checks++; if (obs_out[e] !== exp_rk[e-1]) begin errors++; $display("FAIL known_key[%0d]: got %h expected %h", e, obs_out[e], exp_rk[e-1]); end
      checks++; if (obs_done[e] !== (e == 11)) begin errors++; $display("FAIL known_done[%0d]: got %b expected %b", e, obs_done[e], e == 11); end
      if (e <= 10) begin
        checks++; if (obs_busy[e] !== 1'b1) begin errors++; $display("FAIL known_busy[%0d]: got %b expected 1", e, obs_busy[e]); end
      end
    end
    checks++; if (obs_valid[12] !== 1'b0) begin errors++; $display("FAIL known_valid_end: got %b expected 0", obs_valid[12]); end
    checks++; if (obs_busy[12] !== 1'b0) begin errors++; $display("FAIL known_busy_end: got %b expected 0", obs_busy[12]); end
    checks++; if (obs_done[12] !== 1'b0) begin errors++; $display("FAIL known_done_end: got %b expected 0", obs_done[12]); end
`ifdef KEY_STORE_EN
    for (int e = 1; e <= 12; e++) begin
      checks++; if (obs_kv[e] !== (e == 12)) begin errors++; $display("FAIL known_keys_valid[%0d]: got %b expected %b", e, obs_kv[e], e == 12); end
    end
    bus.rd_addr = 4'd1; tick();
    checks++; if (bus.rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL bank_rd1: got %h expected a0fafe1788542cb123a339392a6c7605", bus.rd_key); end
    bus.rd_addr = 4'd10; tick();
    checks++; if (bus.rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL bank_rd10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", bus.rd_key); end
    bus.rd_addr = 4'd12; tick();
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL bank_rd12: got %h expected 0", bus.rd_key); end
    checks++; if (bus.keys_valid !== 1'b1) begin errors++; $display("FAIL bank_keys_valid: got %b expected 1", bus.keys_valid); end
`else
    for (int e = 1; e <= 12; e++) begin
      checks++; if (obs_rdk[e] !== 128'h0) begin errors++; $display("FAIL nobank_rd_key[%0d]: got %h expected 0", e, obs_rdk[e]); end
      checks++; if (obs_kv[e] !== 1'b0) begin errors++; $display("FAIL nobank_keys_valid[%0d]: got %b expected 0", e, obs_kv[e]); end
    end
`endif
  endtask

  task automatic test_zero_key;
    model_expand(128'h0);
    capture(128'h0, 1'b0, -1, -1, 12);
    checks++; if (obs_out[2] !== 128'h62636363626363636263636362636363) begin errors++; $display("FAIL zero_round1: got %h expected 62636363626363636263636362636363", obs_out[2]); end
    checks++; if (obs_out[11] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin errors++; $display("FAIL zero_round10: got %h expected b4ef5bcb3e92e21123e951cf6f8f188e", obs_out[11]); end
    for (int e = 1; e <= 11; e++) begin
      checks++; if (obs_out[e] !== exp_rk[e-1]) begin errors++; $display("FAIL zero_key[%0d]: got %h expected %h", e, obs_out[e], exp_rk[e-1]); end
    end
  endtask

  task automatic test_ignore_start;
    logic [127:0] key;
    key = rand128();
    model_expand(key);
    capture(key, 1'b0, 5, -1, 12);
    for (int e = 1; e <= 11; e++) begin
      checks++; if (obs_valid[e] !== 1'b1 || obs_round[e] !== 4'(e - 1) || obs_out[e] !== exp_rk[e-1]) begin
        errors++; $display("FAIL ignore_start[%0d]: got v=%b r=%0d k=%h expected v=1 r=%0d k=%h", e, obs_valid[e], obs_round[e], obs_out[e], e - 1, exp_rk[e-1]);
      end
      checks++; if (obs_done[e] !== (e == 11)) begin errors++; $display("FAIL ignore_done[%0d]: got %b expected %b", e, obs_done[e], e == 11); end
    end
    checks++; if (obs_valid[12] !== 1'b0 || obs_busy[12] !== 1'b0) begin errors++; $display("FAIL ignore_end: got v=%b busy=%b expected v=0 busy=0", obs_valid[12], obs_busy[12]); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] key;
    key = rand128();
    model_expand(key);
    capture(key, 1'b0, -1, 6, 7);
    for (int e = 1; e <= 5; e++) begin
      checks++; if (obs_round[e] !== 4'(e - 1) || obs_out[e] !== exp_rk[e-1]) begin
        errors++; $display("FAIL pre_rst[%0d]: got r=%0d k=%h expected r=%0d k=%h", e, obs_round[e], obs_out[e], e - 1, exp_rk[e-1]);
      end
    end
    checks++; if (obs_valid[6] !== 1'b0 || obs_round[6] !== 4'd0 || obs_out[6] !== 128'h0 || obs_done[6] !== 1'b0 || obs_busy[6] !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got v=%b r=%0d k=%h d=%b b=%b expected all 0", obs_valid[6], obs_round[6], obs_out[6], obs_done[6], obs_busy[6]);
    end
    checks++; if (obs_kv[6] !== 1'b0 || obs_rdk[6] !== 128'h0) begin errors++; $display("FAIL mid_rst_bank: got kv=%b rd=%h expected 0", obs_kv[6], obs_rdk[6]); end
    checks++; if (obs_valid[7] !== 1'b0 || obs_busy[7] !== 1'b0 || obs_done[7] !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got v=%b b=%b d=%b expected 0", obs_valid[7], obs_busy[7], obs_done[7]); end
    key = rand128();
    model_expand(key);
    capture(key, 1'b0, -1, -1, 12);
    for (int e = 1; e <= 11; e++) begin
      checks++; if (obs_valid[e] !== 1'b1 || obs_round[e] !== 4'(e - 1) || obs_out[e] !== exp_rk[e-1]) begin
        errors++; $display("FAIL restart_stream[%0d]: got v=%b r=%0d k=%h expected v=1 r=%0d k=%h", e, obs_valid[e], obs_round[e], obs_out[e], e - 1, exp_rk[e-1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] key;
    key = rand128();
    model_expand(key);
    exp_a = exp_rk;
    capture(key, 1'b1, -1, -1, 24);
    model_expand(obs_kin[12]);
    for (int e = 1; e <= 11; e++) begin
      checks++; if (obs_valid[e] !== 1'b1 || obs_round[e] !== 4'(e - 1) || obs_out[e] !== exp_a[e-1]) begin
        errors++; $display("FAIL b2b_first[%0d]: got v=%b r=%0d k=%h expected v=1 r=%0d k=%h", e, obs_valid[e], obs_round[e], obs_out[e], e - 1, exp_a[e-1]);
      end
      checks++; if (obs_valid[e+12] !== 1'b1 || obs_round[e+12] !== 4'(e - 1) || obs_out[e+12] !== exp_rk[e-1]) begin
        errors++; $display("FAIL b2b_second[%0d]: got v=%b r=%0d k=%h expected v=1 r=%0d k=%h", e, obs_valid[e+12], obs_round[e+12], obs_out[e+12], e - 1, exp_rk[e-1]);
      end
    end
    checks++; if (obs_valid[12] !== 1'b0) begin errors++; $display("FAIL b2b_gap1: got %b expected 0", obs_valid[12]); end
    checks++; if (obs_valid[24] !== 1'b0) begin errors++; $display("FAIL b2b_gap2: got %b expected 0", obs_valid[24]); end
    for (int i = 0; i < 13; i++) tick();
    checks++; if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b v=%b expected 0", bus.busy, bus.rk_valid); end
  endtask

  task automatic test_random_keys;
    logic [127:0] key;
    logic [3:0]   a;
    logic [127:0] want;
    for (int n = 0; n < 4; n++) begin
      key = rand128();
      model_expand(key);
      capture(key, 1'b0, -1, -1, 12);
      for (int e = 1; e <= 11; e++) begin
        checks++; if (obs_round[e] !== 4'(e - 1) || obs_out[e] !== exp_rk[e-1]) begin
          errors++; $display("FAIL rand%0d_key[%0d]: got r=%0d k=%h expected r=%0d k=%h", n, e, obs_round[e], obs_out[e], e - 1, exp_rk[e-1]);
        end
      end
`ifdef KEY_STORE_EN
      for (int j = 0; j < 3; j++) begin
        a = 4'($urandom_range(0, 15));
        want = (a <= 4'd10) ? exp_rk[a] : 128'h0;
        bus.rd_addr = a;
        tick();
        checks++; if (bus.rd_key !== want) begin errors++; $display("FAIL rand%0d_bank[%0d]: got %h expected %h", n, a, bus.rd_key, want); end
      end
`else
      checks++; if (bus.rd_key !== 128'h0 || bus.keys_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_nobank: got rd=%h kv=%b expected 0", n, bus.rd_key, bus.keys_valid); end
`endif
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.rd_addr = '0;
    build_sbox();
    test_reset();
    test_known_key();
    test_zero_key();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
